// File: rtl/accel_spi_reader.sv
// SPI mode-3 master for an ADXL345-style accelerometer: one configuration write
// after reset, then periodic 2-byte burst reads of one axis, presented as a signed sample.
module accel_spi_reader #(
    parameter int         CLK_DIV       = 25,
    parameter int         SAMPLE_PERIOD = 500000,
    parameter logic [7:0] REG_ADDR      = 8'h32,
    parameter logic [7:0] CFG_ADDR      = 8'h2D,
    parameter logic [7:0] CFG_DATA      = 8'h08
) (
    input  logic        clk,
    input  logic        rst,
    output logic        sclk,
    output logic        cs_n,
    output logic        mosi,
    input  logic        miso,
    output logic [15:0] accel,
    output logic        accel_valid,
    output logic        busy
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int TMR_W = $clog2(SAMPLE_PERIOD);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SAMPLE_PERIOD - 1);

    localparam logic [7:0]  WR_CMD   = CFG_ADDR & 8'h3F;
    localparam logic [7:0]  RD_CMD   = 8'hC0 | (REG_ADDR & 8'h3F);
    localparam logic [23:0] WR_FRAME = {WR_CMD, CFG_DATA, 8'h00};
    localparam logic [23:0] RD_FRAME = {RD_CMD, 16'h0000};

    typedef enum logic [2:0] {
        S_INIT,
        S_XFER,
        S_GAP,
        S_WAIT,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [DIV_W-1:0]    r_div;
    logic [5:0]          r_half;
    logic                r_rd;
    logic [23:0]         r_tx;
    logic [15:0]         r_rx;
    logic [TMR_W-1:0]    r_timer;
    logic                r_sclk;
    logic                r_cs_n;
    logic                r_mosi;
    logic [15:0]         r_accel;

    logic                w_div_end;
    logic [5:0]          w_half_last;
    logic                w_xfer_end;
    logic                w_gap_end;
    logic                w_tmr_hit;
    logic                w_load_wr;
    logic                w_load_rd;

    // Half-period index 0 is the lead-in high phase; odd indices are sclk-low phases.
    assign w_div_end   = (r_div == DIV_LAST);
    assign w_half_last = r_rd ? 6'd48 : 6'd32;
    assign w_xfer_end  = (r_state == S_XFER) && w_div_end && (r_half == w_half_last);
    assign w_gap_end   = (r_state == S_GAP) && w_div_end;
    assign w_tmr_hit   = (r_timer == TMR_LAST);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_INIT;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_load_wr = 1'b0;
        w_load_rd = 1'b0;
        case (r_state)
            S_INIT: begin
                w_next    = S_XFER;
                w_load_wr = 1'b1;
            end
            S_XFER: if (w_xfer_end) w_next = S_GAP;
            S_GAP: begin
                if (w_div_end) begin
                    if (r_rd) begin
                        w_next = S_DONE;
                    end else begin
                        w_next    = S_XFER;
                        w_load_rd = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (w_tmr_hit) begin
                    w_next    = S_XFER;
                    w_load_rd = 1'b1;
                end
            end
            S_DONE: begin
                // A late expiry (transaction longer than the period) starts the read right here.
                if (w_tmr_hit) begin
                    w_next    = S_XFER;
                    w_load_rd = 1'b1;
                end else begin
                    w_next = S_WAIT;
                end
            end
            default: w_next = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div   <= '0;
            r_half  <= '0;
            r_rd    <= 1'b0;
            r_tx    <= '0;
            r_rx    <= '0;
            r_timer <= '0;
            r_sclk  <= 1'b1;
            r_cs_n  <= 1'b1;
            r_mosi  <= 1'b0;
            r_accel <= '0;
        end else begin
            if ((r_state == S_XFER || r_state == S_GAP) && !w_div_end) r_div <= r_div + 1'b1;
            else                                                       r_div <= '0;

            if (w_load_wr || w_load_rd)
                r_half <= '0;
            else if (r_state == S_XFER && w_div_end && !w_xfer_end)
                r_half <= r_half + 6'd1;

            if (w_load_wr) begin
                r_tx   <= WR_FRAME;
                r_rd   <= 1'b0;
                r_cs_n <= 1'b0;
            end else if (w_load_rd) begin
                r_tx   <= RD_FRAME;
                r_rd   <= 1'b1;
                r_cs_n <= 1'b0;
            end else if (r_state == S_XFER && w_div_end) begin
                if (w_xfer_end) begin
                    r_cs_n <= 1'b1;
                    r_mosi <= 1'b0;
                end else if (r_sclk) begin
                    r_sclk <= 1'b0;
                    r_mosi <= r_tx[23];
                    r_tx   <= {r_tx[22:0], 1'b0};
                end else begin
                    r_sclk <= 1'b1;
                    // Only the last 16 of the 24 read bits survive: low byte then high byte.
                    if (r_rd) r_rx <= {r_rx[14:0], miso};
                end
            end

            if (w_gap_end && r_rd) r_accel <= {r_rx[7:0], r_rx[15:8]};

            if (w_load_rd)
                r_timer <= '0;
            else if (r_rd && !w_tmr_hit)
                r_timer <= r_timer + 1'b1;
        end
    end

    assign sclk        = r_sclk;
    assign cs_n        = r_cs_n;
    assign mosi        = r_mosi;
    assign accel       = r_accel;
    assign accel_valid = (r_state == S_DONE);
    assign busy        = (r_state == S_XFER) || (r_state == S_GAP);

endmodule

// File: tb/tb_accel_spi_reader.sv
// Bench for accel_spi_reader: mode-3 sensor model, frame-timing monitor and an
// accel scoreboard fed when each read frame begins.
module tb_accel_spi_reader;

    localparam int CLK_DIV = 2;
    localparam int PERIOD  = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sclk, cs_n, mosi;
    logic        miso = 1'b0;
    logic [15:0] accel;
    logic        accel_valid, busy;

    accel_spi_reader #(
        .CLK_DIV      (CLK_DIV),
        .SAMPLE_PERIOD(PERIOD),
        .REG_ADDR     (8'h32),
        .CFG_ADDR     (8'h2D),
        .CFG_DATA     (8'h08)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sclk       (sclk),
        .cs_n       (cs_n),
        .mosi       (mosi),
        .miso       (miso),
        .accel      (accel),
        .accel_valid(accel_valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    logic [15:0] stim_q[$];
    logic [15:0] sb_q[$];

    int          cyc = 0;
    logic        prev_sclk = 1'b1, prev_cs = 1'b1, prev_mosi = 1'b0, prev_valid = 1'b0;
    bit          in_frame = 0, cur_is_read = 0, expect_write = 1, first_read = 0;
    int          low_cnt = 0, rises = 0;
    logic [23:0] mosi_sr = '0, miso_word = '0;
    int          last_rd_start = -1, last_valid = -1, wr_end = -1, rd_end = -1;
    logic [15:0] exp_hold = '0;
    int          valid_cnt = 0;

    // Sensor model and monitor, all sampled on the falling clk edge.
    always @(negedge clk) begin
        logic [15:0] v;
        cyc++;
        if (rst) begin
            expect_write  = 1;
            in_frame      = 0;
            sb_q.delete();
            last_rd_start = -1;
            last_valid    = -1;
            wr_end        = -1;
            rd_end        = -1;
            exp_hold      = '0;
        end else begin
            if (prev_cs && !cs_n) begin
                in_frame = 1;
                low_cnt  = 1;
                rises    = 0;
                mosi_sr  = '0;
                check("busy_xfer", busy, 1'b1);
                if (expect_write) begin
                    cur_is_read  = 0;
                    expect_write = 0;
                    first_read   = 1;
                end else begin
                    cur_is_read = 1;
                    v = (stim_q.size() > 0) ? stim_q.pop_front() : 16'($urandom_range(0, 65535));
                    miso_word = {8'hA5, v[7:0], v[15:8]};
                    sb_q.push_back(v);
                    if (first_read) begin
                        check("wr_to_rd", cyc - wr_end, CLK_DIV);
                        first_read = 0;
                    end
                    if (last_rd_start >= 0) check("rd_period", cyc - last_rd_start, PERIOD);
                    last_rd_start = cyc;
                end
            end else if (!prev_cs && cs_n && in_frame) begin
                in_frame = 0;
                if (cur_is_read) begin
                    check("rd_rises", rises, 24);
                    check("rd_len", low_cnt, CLK_DIV * 49);
                    check("rd_cmd", mosi_sr[23:16], 8'hF2);
                    check("rd_pad", mosi_sr[15:0], 16'h0000);
                    rd_end = cyc;
                end else begin
                    check("wr_rises", rises, 16);
                    check("wr_len", low_cnt, CLK_DIV * 33);
                    check("wr_frame", mosi_sr[15:0], 16'h2D08);
                    wr_end = cyc;
                end
            end else if (!cs_n) begin
                low_cnt++;
            end

            if (!cs_n && prev_sclk && !sclk) begin
                miso = cur_is_read ? miso_word[23 - rises] : 1'($urandom_range(0, 1));
            end else if (!cs_n && !prev_sclk && sclk) begin
                check("mosi_stable", mosi, prev_mosi);
                mosi_sr = {mosi_sr[22:0], mosi};
                rises++;
            end else if (cs_n) begin
                miso = 1'($urandom_range(0, 1));
            end

            if (accel_valid) begin
                valid_cnt++;
                check("valid_1cyc", prev_valid, 1'b0);
                check("busy_done", busy, 1'b0);
                if (sb_q.size() > 0) begin
                    v = sb_q.pop_front();
                    check("accel", accel, v);
                    exp_hold = v;
                    check("rd_to_valid", cyc - rd_end, CLK_DIV);
                end else begin
                    check("spurious_valid", accel_valid, 1'b0);
                end
                if (last_valid >= 0) check("valid_period", cyc - last_valid, PERIOD);
                last_valid = cyc;
            end else begin
                check("accel_hold", accel, exp_hold);
            end
        end
        prev_sclk  = sclk;
        prev_cs    = cs_n;
        prev_mosi  = mosi;
        prev_valid = accel_valid;
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sclk"}, sclk, 1'b1);
        check({tag, "_cs_n"}, cs_n, 1'b1);
        check({tag, "_mosi"}, mosi, 1'b0);
        check({tag, "_accel"}, accel, 16'h0000);
        check({tag, "_valid"}, accel_valid, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    task automatic wait_valids(input int target, input int budget, input string tag);
        for (int i = 0; i < budget && valid_cnt < target; i++) @(negedge clk);
        check(tag, valid_cnt >= target, 1'b1);
    endtask

    initial begin
        stim_q = '{16'h1234, 16'h8000, 16'hFFFF, 16'h7FFF, 16'h0001};

        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        wait_valids(5, 1600, "timeout_first");

        // Reset held for 5 cycles while reads are running.
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst_stream");
        repeat (4) @(posedge clk);
        #2 rst = 1'b0;

        stim_q.push_back(16'h0000);
        stim_q.push_back(16'hFEDC);
        wait_valids(valid_cnt + 2, 1000, "timeout_after_rst");

        // Reset after exactly 10 bits of a read frame.
        begin
            int i;
            for (i = 0; i < 1000; i++) begin
                @(negedge clk);
                if (in_frame && cur_is_read && rises == 10) break;
            end
            check("timeout_bit10", i < 1000, 1'b1);
        end
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst_midread");
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        stim_q.push_back(16'h4321);
        wait_valids(valid_cnt + 3, 1200, "timeout_final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/accel_spi_reader.md
Name: accel_spi_reader

Overview:
Upstream stage of beatmaker. SPI master that configures a 3-axis digital accelerometer (ADXL345-style register map) after reset, then periodically burst-reads one 16-bit axis register pair. Presents the result as a signed 16-bit sample on accel, which feeds beatmaker's accel input directly, plus a one-cycle accel_valid strobe.

Parameters:
CLK_DIV, 25, clk cycles per SCLK half-period (>=2)
SAMPLE_PERIOD, 500000, clk cycles between starts of consecutive read transactions (must exceed read transaction length)
REG_ADDR, 8'h32, low-byte register address of the axis to read (high byte at REG_ADDR+1)
CFG_ADDR, 8'h2D, configuration register written once after reset
CFG_DATA, 8'h08, value written to CFG_ADDR (measure mode)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
sclk  out  1  SPI clock, idles high (mode 3)
cs_n  out  1  SPI chip select, active low
mosi  out  1  SPI data to sensor
miso  in  1  SPI data from sensor
accel  out  16  signed sample {high byte, low byte}, held until next sample
accel_valid  out  1  one-cycle pulse when accel updates
busy  out  1  high while cs_n is low or in the post-transaction gap

Behaviour:
- Reset values: sclk=1, cs_n=1, mosi=0, accel=0, accel_valid=0, busy=0; FSM to INIT; sample timer cleared.
- rst asserted on any cycle (including mid-transaction): outputs take reset values on the next edge; partial data discarded; no accel_valid; init write repeats after release.
- States: INIT -> XFER(write) -> GAP -> WAIT -> XFER(read) -> GAP -> DONE -> WAIT ...
- INIT: one cycle after rst release, load 16-bit write frame {CFG_ADDR & 8'h3F, CFG_DATA} (bit7=0 write, bit6=0 single), go to XFER.
- Read frame: 24 bits; command byte 8'hC0 | (REG_ADDR & 8'h3F) (read, multibyte), then 16 don't-care bits (mosi=0).
- XFER timing: cs_n falls; after CLK_DIV cycles with sclk high, each bit = CLK_DIV cycles sclk low then CLK_DIV cycles sclk high. mosi updated (MSB first) on the cycle sclk falls; miso sampled on the cycle sclk rises. After the last high phase, cs_n rises; total cs_n-low time = CLK_DIV*(1+2*N) cycles, N = bit count.
- GAP: cs_n high, sclk high for CLK_DIV cycles, busy stays high.
- Read assembly: bits 8..15 received = low byte, bits 16..23 = high byte, both MSB first; accel = {high, low} as two's complement, no sign manipulation.
- DONE: accel loaded and accel_valid=1 for exactly one cycle, on the cycle after GAP ends.
- Sample timer: counts every cycle after the init write's GAP; a read starts when it reaches SAMPLE_PERIOD-1, timer resets at each read start, so read starts are exactly SAMPLE_PERIOD cycles apart. First read starts on the cycle after the init write's GAP. If a timer expiry coincides with an active transaction (illegal parameterisation), the read starts on the cycle after DONE; never overlap.
- accel holds its value between pulses; unchanged by the init write.
- miso ignored outside read-frame sample points.

Test Plan:
- Reset: hold rst 5 cycles mid-stream -> next edge sclk=1, cs_n=1, accel=0, accel_valid=0; after release exactly one 16-bit write frame, mosi bits = 0x2D,0x08.
- Frame timing, CLK_DIV=2: cs_n low for 2*(1+2*16)=66 cycles on write, 98 cycles on read; sclk has 16/24 rising edges respectively; mosi stable across each rising edge.
- Positive sample: sensor model returns 0x34 then 0x12 -> accel=16'sh1234 (4660) with a single-cycle accel_valid; command byte observed = 0xF2.
- Negative boundary: model returns 0x00, 0x80 -> accel=-32768; then 0xFF, 0xFF -> accel=-1; beatmaker input sees these values unchanged.
- Periodicity, CLK_DIV=2, SAMPLE_PERIOD=200: successive cs_n falling edges of reads exactly 200 cycles apart; accel_valid pulses 200 cycles apart; accel held constant between pulses.
- Reset mid-read after 10 bits: cs_n high next cycle, no accel_valid, accel=0, init write re-issued before next read.
